// File: rtl/ula_iniciador_if.sv
// Command handshake with the core plus the operand/result bus to the combinational ALU.
// The slave modport is the requester's view; the master modport is the core+ALU side.
interface ula_iniciador_if #(
    parameter int LARGURA = 8
);
    logic               inicio;
    logic [2:0]         cmd;
    logic [LARGURA-1:0] opA;
    logic [LARGURA-1:0] opB;
    logic               pronto;
    logic               concluido;
    logic [LARGURA-1:0] resultado;
    logic               desvio;
    logic [1:0]         ULAOp;
    logic [LARGURA-1:0] dado1;
    logic [LARGURA-1:0] dado2;
    logic [LARGURA-1:0] saidaULA;
    logic               zero;

    modport master (
        output inicio, cmd, opA, opB, saidaULA, zero,
        input  pronto, concluido, resultado, desvio, ULAOp, dado1, dado2
    );

    modport slave (
        input  inicio, cmd, opA, opB, saidaULA, zero,
        output pronto, concluido, resultado, desvio, ULAOp, dado1, dado2
    );
endinterface

// File: rtl/ula_iniciador.sv
// Multi-cycle ALU requester: single-op commands, branch decisions and an 8-step
// shift-add signed multiply, with every addition done by the external ALU.
module ula_iniciador #(
    parameter int LARGURA    = 8,
    parameter int PASSOS_MUL = 8
) (
    input  logic              clock,
    input  logic              reset,
    ula_iniciador_if.slave    ula_if,
    output logic [1:0]        estado_dbg_o
);
    localparam int CW = (PASSOS_MUL > 1) ? $clog2(PASSOS_MUL) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(PASSOS_MUL - 1);

    localparam logic [2:0] CMD_ADD = 3'b000;
    localparam logic [2:0] CMD_SUB = 3'b001;
    localparam logic [2:0] CMD_SLT = 3'b010;
    localparam logic [2:0] CMD_BEQ = 3'b011;
    localparam logic [2:0] CMD_BNE = 3'b100;
    localparam logic [2:0] CMD_MUL = 3'b101;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        EXECUTA    = 2'd1,
        MULTIPLICA = 2'd2,
        FIM        = 2'd3
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [LARGURA-1:0] a_q, a_d;
    logic [LARGURA-1:0] b_q, b_d;
    logic [LARGURA-1:0] acc_q, acc_d;
    logic [LARGURA-1:0] mcand_q, mcand_d;
    logic [LARGURA-1:0] mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic [LARGURA-1:0] resultado_q, resultado_d;
    logic               desvio_q, desvio_d;

    logic [1:0]         ula_op;
    logic [LARGURA-1:0] dado1, dado2;
    logic               pronto, concluido;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            cmd_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            count_q     <= '0;
            resultado_q <= '0;
            desvio_q    <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cmd_q       <= cmd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            count_q     <= count_d;
            resultado_q <= resultado_d;
            desvio_q    <= desvio_d;
        end
    end

    // Handshake: a command is accepted on any edge where pronto=1 and inicio=1;
    // inicio is ignored otherwise, and concluido pulses for exactly one cycle
    // when resultado/desvio carry the answer for that command.
    always_comb begin
        estado_d    = estado_q;
        cmd_d       = cmd_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
        resultado_d = resultado_q;
        desvio_d    = desvio_q;
        ula_op      = 2'b11;
        dado1       = '0;
        dado2       = '0;
        pronto      = 1'b0;
        concluido   = 1'b0;

        case (estado_q)
            OCIOSO: begin
                pronto = 1'b1;
                if (ula_if.inicio) begin
                    cmd_d = ula_if.cmd;
                    a_d   = ula_if.opA;
                    b_d   = ula_if.opB;
                    if (ula_if.cmd == CMD_MUL) begin
                        acc_d    = '0;
                        mcand_d  = ula_if.opA;
                        mplier_d = ula_if.opB;
                        count_d  = '0;
                        estado_d = MULTIPLICA;
                    end else begin
                        estado_d = EXECUTA;
                    end
                end
            end

            EXECUTA: begin
                case (cmd_q)
                    CMD_ADD: begin
                        ula_op = 2'b00;
                        dado1  = a_q;
                        dado2  = b_q;
                    end
                    CMD_SUB, CMD_BEQ, CMD_BNE: begin
                        ula_op = 2'b01;
                        dado1  = a_q;
                        dado2  = b_q;
                    end
                    CMD_SLT: begin
                        ula_op = 2'b10;
                        dado1  = a_q;
                        dado2  = b_q;
                    end
                    default: begin
                        ula_op = 2'b11;
                    end
                endcase
                resultado_d = ula_if.saidaULA;
                if (cmd_q == CMD_BEQ) begin
                    desvio_d = ula_if.zero;
                end else if (cmd_q == CMD_BNE) begin
                    desvio_d = ~ula_if.zero;
                end else begin
                    desvio_d = 1'b0;
                end
                estado_d = FIM;
            end

            MULTIPLICA: begin
                // Low bits of a signed product only need the multiplier's raw bit pattern.
                ula_op   = 2'b00;
                dado1    = acc_q;
                dado2    = mplier_q[0] ? mcand_q : '0;
                acc_d    = ula_if.saidaULA;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == ULTIMO) begin
                    resultado_d = ula_if.saidaULA;
                    desvio_d    = 1'b0;
                    estado_d    = FIM;
                end
            end

            FIM: begin
                concluido = 1'b1;
                estado_d  = OCIOSO;
            end

            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    assign ula_if.pronto    = pronto;
    assign ula_if.concluido = concluido;
    assign ula_if.resultado = resultado_q;
    assign ula_if.desvio    = desvio_q;
    assign ula_if.ULAOp     = ula_op;
    assign ula_if.dado1     = dado1;
    assign ula_if.dado2     = dado2;
    assign estado_dbg_o     = estado_q;
endmodule

// File: tb/tb_ula_iniciador.sv
// Directed bench for ula_iniciador with a behavioural 8-bit ALU attached to its bus.
module tb_ula_iniciador;
    logic       clock;
    logic       reset;
    logic [1:0] estado_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    ula_iniciador_if #(.LARGURA(8)) u_if ();

    ula_iniciador #(
        .LARGURA    (8),
        .PASSOS_MUL (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ula_if       (u_if.slave),
        .estado_dbg_o (estado_dbg)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Combinational ALU: 00 add, 01 sub, 10 signed slt, 11 zero.
    logic [7:0] alu_res;
    always_comb begin
        alu_res = 8'h00;
        case (u_if.ULAOp)
            2'b00: alu_res = u_if.dado1 + u_if.dado2;
            2'b01: alu_res = u_if.dado1 - u_if.dado2;
            2'b10: alu_res = ($signed(u_if.dado1) < $signed(u_if.dado2)) ? 8'd1 : 8'd0;
            default: alu_res = 8'h00;
        endcase
    end
    assign u_if.saidaULA = alu_res;
    assign u_if.zero     = (alu_res == 8'h00);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Driver: issue one command, follow it through to FIM and back to OCIOSO.
    task automatic run_cmd(input string tag, input logic [2:0] c, input logic [7:0] a,
                           input logic [7:0] b, input logic [1:0] op_exp,
                           input logic [7:0] res_exp, input logic des_exp);
        logic [7:0] r;
        exp_q.push_back(res_exp);
        @(negedge clock);
        u_if.inicio = 1'b1;
        u_if.cmd    = c;
        u_if.opA    = a;
        u_if.opB    = b;
        tick();
        u_if.inicio = 1'b0;
        chk({tag, "_pronto_busy"}, u_if.pronto, 1'b0);
        if (c == 3'b101) begin
            for (int i = 0; i < 8; i++) begin
                chk({tag, "_mul_op"}, u_if.ULAOp, 2'b00);
                chk({tag, "_mul_nodone"}, u_if.concluido, 1'b0);
                tick();
            end
        end else begin
            chk({tag, "_op"}, u_if.ULAOp, op_exp);
            chk({tag, "_nodone"}, u_if.concluido, 1'b0);
            tick();
        end
        r = exp_q.pop_front();
        chk({tag, "_done"}, u_if.concluido, 1'b1);
        chk({tag, "_res"}, u_if.resultado, r);
        chk({tag, "_desvio"}, u_if.desvio, des_exp);
        tick();
        chk({tag, "_done_pulse"}, u_if.concluido, 1'b0);
        chk({tag, "_pronto_idle"}, u_if.pronto, 1'b1);
        chk({tag, "_res_hold"}, u_if.resultado, r);
    endtask

    initial begin
        logic saw_done;
        reset       = 1'b1;
        u_if.inicio = 1'b0;
        u_if.cmd    = 3'b000;
        u_if.opA    = 8'h00;
        u_if.opB    = 8'h00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_pronto", u_if.pronto, 1'b1);
        chk("rst_done", u_if.concluido, 1'b0);
        chk("rst_res", u_if.resultado, 8'h00);
        chk("rst_desvio", u_if.desvio, 1'b0);
        chk("rst_op", u_if.ULAOp, 2'b11);
        chk("rst_dado1", u_if.dado1, 8'h00);

        run_cmd("add_2_3",   3'b000, 8'd2,   8'd3,   2'b00, 8'd5,  1'b0);
        run_cmd("beq_eq",    3'b011, 8'hFD,  8'hFD,  2'b01, 8'd0,  1'b1);
        run_cmd("bne_eq",    3'b100, 8'hFD,  8'hFD,  2'b01, 8'd0,  1'b0);
        run_cmd("bne_5_3",   3'b100, 8'd5,   8'd3,   2'b01, 8'd2,  1'b1);
        run_cmd("sub_3_5",   3'b001, 8'd3,   8'd5,   2'b01, 8'hFE, 1'b0);
        run_cmd("slt_m3_2",  3'b010, 8'hFD,  8'd2,   2'b10, 8'd1,  1'b0);
        run_cmd("slt_2_m3",  3'b010, 8'd2,   8'hFD,  2'b10, 8'd0,  1'b0);
        run_cmd("rsv_111",   3'b111, 8'd9,   8'd4,   2'b11, 8'd0,  1'b0);
        run_cmd("mul_m3_5",  3'b101, 8'hFD,  8'd5,   2'b00, 8'hF1, 1'b0);
        run_cmd("mul_16_16", 3'b101, 8'd16,  8'd16,  2'b00, 8'h00, 1'b0);
        run_cmd("mul_7_m1",  3'b101, 8'd7,   8'hFF,  2'b00, 8'hF9, 1'b0);

        // inicio held high: MUL 3*4 runs untouched, then ADD 10+20 is taken from live inputs.
        @(negedge clock);
        u_if.inicio = 1'b1;
        u_if.cmd    = 3'b101;
        u_if.opA    = 8'd3;
        u_if.opB    = 8'd4;
        tick();
        u_if.cmd = 3'b000;
        u_if.opA = 8'd10;
        u_if.opB = 8'd20;
        for (int i = 0; i < 8; i++) begin
            chk("hold_pronto", u_if.pronto, 1'b0);
            tick();
        end
        chk("hold_mul_done", u_if.concluido, 1'b1);
        chk("hold_mul_res", u_if.resultado, 8'h0C);
        tick();
        chk("hold_idle_pronto", u_if.pronto, 1'b1);
        chk("hold_idle_nodone", u_if.concluido, 1'b0);
        tick();
        u_if.inicio = 1'b0;
        chk("hold_add_op", u_if.ULAOp, 2'b00);
        chk("hold_add_dado1", u_if.dado1, 8'd10);
        chk("hold_add_dado2", u_if.dado2, 8'd20);
        tick();
        chk("hold_add_done", u_if.concluido, 1'b1);
        chk("hold_add_res", u_if.resultado, 8'd30);
        tick();

        // Reset during the fourth MULTIPLICA cycle aborts silently.
        @(negedge clock);
        u_if.inicio = 1'b1;
        u_if.cmd    = 3'b101;
        u_if.opA    = 8'd3;
        u_if.opB    = 8'd4;
        tick();
        u_if.inicio = 1'b0;
        repeat (3) tick();
        chk("abort_state_mul", estado_dbg, 2'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_pronto", u_if.pronto, 1'b1);
        chk("abort_res", u_if.resultado, 8'h00);
        chk("abort_desvio", u_if.desvio, 1'b0);
        chk("abort_nodone", u_if.concluido, 1'b0);
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (u_if.concluido) saw_done = 1'b1;
            tick();
        end
        chk("abort_no_late_done", saw_done, 1'b0);
        run_cmd("add_after_abort", 3'b000, 8'd1, 8'd1, 2'b00, 8'd2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end
endmodule
